// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered ALU between the issue and address-generation
// requesters, holding the ALU inputs stable and returning a tagged, back-pressurable response.
module alu_arbiter #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [5:0]       req_op0,
    input  logic [5:0]       req_op1,
    input  logic [W-1:0]     req_rs0,
    input  logic [W-1:0]     req_rs1,
    input  logic [W-1:0]     req_rt0,
    input  logic [W-1:0]     req_rt1,
    input  logic [W-1:0]     req_imm0,
    input  logic [W-1:0]     req_imm1,
    output logic [5:0]       alu_op,
    output logic [W-1:0]     alu_rs,
    output logic [W-1:0]     alu_rt,
    output logic [W-1:0]     alu_imm,
    input  logic [W-1:0]     alu_rd,
    input  logic [W-1:0]     alu_a,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [5:0]       alu_op_q, alu_op_d;
    logic [W-1:0]     alu_rs_q, alu_rs_d;
    logic [W-1:0]     alu_rt_q, alu_rt_d;
    logic [W-1:0]     alu_imm_q, alu_imm_d;
    logic             rsp_id_q, rsp_id_d;
    logic [W-1:0]     rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    logic       grant_any;
    logic       grant_idx;
    logic [1:0] grant_vec;
    logic       accept;
    logic       op_err;
    logic       op_mem;

    // Both valid: favour the requester that did not win last time.
    always_comb begin
        grant_any = |req_valid;
        grant_idx = 1'b0;
        if (req_valid == 2'b11) begin
            grant_idx = ~last_q;
        end else if (req_valid[1]) begin
            grant_idx = 1'b1;
        end
        grant_vec = '0;
        grant_vec[grant_idx] = grant_any;
    end

    assign req_ready = (state_q == IDLE && rst_n) ? grant_vec : '0;
    assign accept    = |req_ready;

    assign op_err = (alu_op_q > 6'h0D);
    assign op_mem = (alu_op_q == 6'h0C) || (alu_op_q == 6'h0D);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        alu_op_d   = alu_op_q;
        alu_rs_d   = alu_rs_q;
        alu_rt_d   = alu_rt_q;
        alu_imm_d  = alu_imm_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        ops_done_d = ops_done_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_d    = grant_idx;
                    rsp_id_d  = grant_idx;
                    alu_op_d  = grant_idx ? req_op1  : req_op0;
                    alu_rs_d  = grant_idx ? req_rs1  : req_rs0;
                    alu_rt_d  = grant_idx ? req_rt1  : req_rt0;
                    alu_imm_d = grant_idx ? req_imm1 : req_imm0;
                    state_d   = EXEC;
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                rsp_err_d  = op_err;
                rsp_data_d = op_err ? '0 : (op_mem ? alu_a : alu_rd);
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    ops_done_d = ops_done_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            alu_op_q   <= '0;
            alu_rs_q   <= '0;
            alu_rt_q   <= '0;
            alu_imm_q  <= '0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            alu_op_q   <= alu_op_d;
            alu_rs_q   <= alu_rs_d;
            alu_rt_q   <= alu_rt_d;
            alu_imm_q  <= alu_imm_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            ops_done_q <= ops_done_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_rs    = alu_rs_q;
    assign alu_rt    = alu_rt_q;
    assign alu_imm   = alu_imm_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);
    assign ops_done  = ops_done_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single registered ALU between two requesters (instruction-issue port 0 and address-generation port 1). It round-robin arbitrates valid/ready requests and drives the ALU operand and opcode inputs from held registers. It waits out the ALU's one-cycle registered latency, captures either `rd` or `A` depending on opcode, and returns the result with a tagged valid/ready response. It sits between the decode/issue logic and the `alu` instance and is the only driver of the ALU inputs.

## Interface
- `W`, 32, datapath width; must match the ALU (32).
- `CNT_W`, 16, width of the completed-operation counter.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i is requester i.
- `req_ready`  out  2  per-requester accept; at most one bit high per cycle.
- `req_op0`, `req_op1`  in  6  opcode per requester.
- `req_rs0`, `req_rs1`, `req_rt0`, `req_rt1`, `req_imm0`, `req_imm1`  in  W  operands per requester.
- `alu_op`  out  6  to ALU `op`; registered.
- `alu_rs`, `alu_rt`, `alu_imm`  out  W  to ALU operands; registered.
- `alu_rd`, `alu_a`  in  W  from ALU `rd` and `A` outputs.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  1  requester index of the response.
- `rsp_data`  out  W  result.
- `rsp_err`  out  1  opcode was not 0x00–0x0D.
- `busy`  out  1  high in any state other than IDLE.
- `ops_done`  out  CNT_W  count of completed responses.

## Operation
- **FSM states:** IDLE, EXEC, CAPT, RESP.
- **IDLE**
  - `req_ready` = grant one-hot, evaluated combinationally.
  - A request is accepted when `req_valid[i] && req_ready[i]`.
  - On acceptance: load the granted requester's op/rs/rt/imm into the `alu_*` registers, latch `rsp_id`, then go to EXEC.
- **Arbitration (round-robin)**
  - `last` register; reset value 1, so requester 0 wins the first contest.
  - If both requesters are valid, grant `~last`.
  - If only one is valid, grant it.
  - `last` updates to the granted index only on acceptance.
- **EXEC:** one cycle. The ALU samples the held `alu_*` inputs at the end of this cycle. Go to CAPT.
- **CAPT:** one cycle.
  - `rsp_data` <= `alu_a` if `alu_op` is 0x0C or 0x0D; 0 if `alu_op` > 0x0D; otherwise `alu_rd`.
  - `rsp_err` <= (`alu_op` > 0x0D).
  - Go to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - `rsp_data`, `rsp_id` and `rsp_err` are held stable until `rsp_ready`.
  - On `rsp_ready`: increment `ops_done` (wraps modulo 2^CNT_W), go to IDLE.
- **ALU input hold:** `alu_*` hold their values in EXEC, CAPT, RESP and IDLE. They change only on acceptance, so the ALU recomputes the same result and `rd`/`A` never glitch.
- **Arithmetic and sign semantics:** none in this block. Operands pass through unmodified and all sign handling belongs to the ALU.
- **Error opcodes:** still sequence through EXEC/CAPT. The ALU zeroes its outputs for these opcodes; the block forces `rsp_data` = 0 regardless.

## Timing
- **Reset values (on `rst_n` low, asynchronous):**
  - State = IDLE.
  - `alu_op`/`alu_rs`/`alu_rt`/`alu_imm` = 0. `alu_op` = 0 is ADD of zeros, which is harmless.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `rsp_err` = 0.
  - `ops_done` = 0, `last` = 1, `busy` = 0.
  - `req_ready` = 0 while reset is asserted.
- **Reset mid-operation:** aborts the transaction and the response is discarded. Operation resumes on the first rising edge after `rst_n` is released.
- **Latency:** acceptance edge E0, EXEC ends at E1, CAPT ends at E2, so `rsp_valid` is high in the cycle after E2.
  - Minimum request-to-request spacing is 4 cycles, because IDLE is re-entered after the `rsp_ready` handshake.
  - With `rsp_ready` tied high, throughput is one operation per 4 cycles.
- **Request side:** `req_ready` is never high outside IDLE. A requester holds valid and payload until accepted. A drop of valid before acceptance is tolerated and no grant occurs.
- **Same-cycle events:** `rsp_ready` and a new `req_valid` in the same RESP cycle do not overlap. The request is accepted no earlier than the next IDLE cycle.
- **Back-pressure:** `rsp_ready` low holds RESP indefinitely. No new requests are accepted during this time.
- **`ops_done` wrap:** 0xFFFF + 1 -> 0x0000, with no flag.

## Test plan
- **Single op:** reset, then req0 valid with op 0x00, rs 5, rt 7, `rsp_ready`=1 -> `req_ready`=01 for one cycle; `alu_op`=0x00 next cycle; `rsp_valid` 3 cycles after acceptance with `rsp_data`=12, `rsp_id`=0, `rsp_err`=0; `ops_done`=1.
- **Load-word path:** req1 op 0x0C, rs 0x100, imm 0x20 -> `rsp_data`=0x120, `rsp_id`=1, taken from `alu_a`.
- **Round-robin:** both requesters held valid continuously for 4 transactions -> grant order 0,1,0,1; `rsp_id` sequence 0,1,0,1.
- **Back-pressure:** `rsp_ready`=0 for 10 cycles in RESP -> `rsp_valid` and `rsp_data` stable, `req_ready`=00, `busy`=1 throughout; `rsp_ready`=1 -> IDLE next cycle.
- **Illegal opcode:** op 0x3F -> `rsp_err`=1, `rsp_data`=0, `ops_done` increments.
- **Reset mid-op:** assert `rst_n` low during EXEC -> all outputs at reset values immediately; after release, req0 op 0x0A, rs 0xF0, rt 0x0F -> `rsp_data`=0xFF with first grant to requester 0.
